cronometro_ctrl: RTL and testbench
==================================

# cronometro_ctrl

Synchronous controller and digit sequencer for the MM:SS display chain. Replaces the ripple-clocked per-digit counters with one clock domain: a prescaler generates a 1 Hz tick, and a mode FSM (stopped / running / set-minutes / set-seconds) sequences four BCD digits with single-cycle carry enables. It sits between the debounced push-button inputs and the 7-segment decoders.

## Interface
- `TICK_DIV`, 50_000_000, clock cycles per 1 s tick (≥2)
- `clock`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears everything
- `btn_start_stop`  in  1  debounced level, synchronous to `clock`
- `btn_clear`  in  1  debounced level
- `btn_mode`  in  1  debounced level
- `btn_inc`  in  1  debounced level
- `down`  in  1  count direction (used only with `COUNTDOWN_EN`)
- `min_tens`  out  4  BCD 0–5
- `min_units`  out  4  BCD 0–9
- `sec_tens`  out  4  BCD 0–5
- `sec_units`  out  4  BCD 0–9
- `state`  out  2  0=STOPPED, 1=RUNNING, 2=SET_MIN, 3=SET_SEC
- `running`  out  1  high in RUNNING
- `rollover`  out  1  one-cycle pulse on 59:59→00:00
- `done`  out  1  one-cycle pulse on reaching 00:00 in countdown

## Operation
- Reset values: all digits 0, `state`=STOPPED, `running`=0, `rollover`=0, `done`=0, prescaler 0, button edge registers 0.
- Buttons: registered once; the action is a rising edge (current=1, previous=0). Holding a button produces one action.
- Priority within a cycle: clear > mode > start_stop > inc.
- Clear edge: digits→00:00 in any state. State is unchanged, except RUNNING→STOPPED.
- FSM:
  - STOPPED: start_stop→RUNNING; mode→SET_MIN.
  - RUNNING: start_stop→STOPPED; mode and inc ignored.
  - SET_MIN: inc adds 1 to minutes, 59→00; mode→SET_SEC; start_stop ignored.
  - SET_SEC: inc adds 1 to seconds, 59→00, with no carry into minutes; mode→STOPPED; start_stop ignored.
- Prescaler: counts 0..TICK_DIV-1 only in RUNNING and is held at 0 in every other state. The tick asserts when the count equals TICK_DIV-1, then the count wraps to 0.
- Up count on tick:
  - sec_units 9→0 carries into sec_tens.
  - sec_tens 5→0 carries into min_units.
  - min_units 9→0 carries into min_tens.
  - min_tens 5→0 completes the wrap 59:59→00:00, pulses `rollover`, and keeps running.
- Digits never leave their BCD ranges. Each carry enable is combinational in the same cycle, so there are no gated or derived clocks.

## Timing
- Button edge to state/digit change: 2 cycles (input register plus action register).
- Entering RUNNING: the first tick occurs TICK_DIV cycles after `running` rises. Digits update on the clock edge after the tick cycle.
- `rollover` and `done` assert in the same cycle the digits show 00:00 and last exactly 1 cycle.
- Pausing with start_stop discards the partial prescaler count; resume restarts a full second.
- A tick coinciding with a start_stop edge is honoured: digits advance, then the state goes to STOPPED.
- A tick coinciding with a clear edge is dropped, and the result is 00:00.
- Reset mid-count returns to reset values immediately, asynchronously.

## Configuration
- `COUNTDOWN_EN` defined:
  - In RUNNING with `down`=1, each tick decrements the digits with borrow (00→59 per field pair).
  - Reaching 00:00 pulses `done` and forces STOPPED in the same edge.
  - Start_stop from STOPPED at 00:00 with `down`=1 is ignored.
  - With `down`=0, the counter counts up as usual.
- `COUNTDOWN_EN` undefined: `down` is ignored, `done` is tied 0, and the counter is up-count only. The port list is identical in both builds.

## Test plan
- Reset while RUNNING at 12:34 → all outputs 0 the same cycle, including `state`=0 and `running`=0.
- TICK_DIV=4, start from 00:00, run 40 cycles → 00:10. Holding start_stop high does not re-toggle.
- Preload 59:58 via SET_MIN/SET_SEC, then run 2 ticks → 59:59 then 00:00 with `rollover` high for 1 cycle, still RUNNING.
- SET_SEC at 59 plus one inc → seconds 00, minutes unchanged. Mode ×3 from STOPPED returns to STOPPED.
- Clear edge and tick in the same cycle while RUNNING at 00:09 → 00:00, STOPPED.
- `COUNTDOWN_EN`: set 01:00, `down`=1, run 60 ticks → 00:59 after the first tick, 00:00 after the last, `done` pulses once, `state`=STOPPED. A further start_stop is ignored.

Source files
------------

// File: rtl/cronometro_ctrl.sv
// cronometro_ctrl -- single-clock MM:SS stopwatch controller.
//
// A prescaler derives a 1 s tick from the system clock. A four-state mode FSM
// (STOPPED / RUNNING / SET_MIN / SET_SEC) sequences four BCD digits. The carry
// and borrow chain between digits is combinational within one clock edge.
//
// Optional feature: define COUNTDOWN_EN to enable counting down (`down`=1)
// with a `done` pulse at 00:00. Without it, `down` has no effect and `done`
// stays 0. The port list is the same in both builds.
//
// Ports:
//   clock           system clock, rising edge
//   reset           asynchronous, active-high; clears all state
//   btn_start_stop  debounced level: toggles STOPPED <-> RUNNING
//   btn_clear       debounced level: digits -> 00:00; RUNNING -> STOPPED
//   btn_mode        debounced level: STOPPED -> SET_MIN -> SET_SEC -> STOPPED
//   btn_inc         debounced level: +1 to the field being set
//   down            count direction (only honoured with COUNTDOWN_EN)
//   min_tens/min_units/sec_tens/sec_units  BCD digits
//   state           0=STOPPED 1=RUNNING 2=SET_MIN 3=SET_SEC
//   running         high in RUNNING
//   rollover        one-cycle pulse on the up-count wrap 59:59 -> 00:00
//   done            one-cycle pulse on reaching 00:00 while counting down
module cronometro_ctrl #(
   parameter int TICK_DIV = 50_000_000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       btn_start_stop,
   input  logic       btn_clear,
   input  logic       btn_mode,
   input  logic       btn_inc,
   input  logic       down,
   output logic [3:0] min_tens,
   output logic [3:0] min_units,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_units,
   output logic [1:0] state,
   output logic       running,
   output logic       rollover,
   output logic       done
);

   localparam int CW = $clog2(TICK_DIV);
   localparam logic [CW-1:0] CNT_MAX = CW'(TICK_DIV - 1);

`ifdef COUNTDOWN_EN
   localparam logic CD_EN = 1'b1;
`else
   localparam logic CD_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      ST_STOPPED = 2'd0,
      ST_RUNNING = 2'd1,
      ST_SET_MIN = 2'd2,
      ST_SET_SEC = 2'd3
   } state_e;

   // Bit positions inside the button vectors.
   localparam int B_SS   = 0;
   localparam int B_CLR  = 1;
   localparam int B_MODE = 2;
   localparam int B_INC  = 3;

   // Button semantics: each input is registered once (btn_q), then delayed
   // once more (btn_prev_q). An action is a cycle where btn_q=1 and
   // btn_prev_q=0, so a held button yields exactly one action. The action
   // takes effect on the following clock edge.
   logic [3:0] btn_in;
   logic [3:0] btn_q, btn_prev_q, btn_edge;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [3:0]    mt_q, mu_q, st_q, su_q;
   logic [3:0]    mt_d, mu_d, st_d, su_d;
   logic          rollover_q, rollover_d;
   logic          done_q, done_d;

   logic          tick;
   logic          count_down;
   logic          at_zero;
   logic [3:0]    nx_mt, nx_mu, nx_st, nx_su;
   logic          nx_wrap;
   logic          nx_zero;

   assign btn_in   = {btn_inc, btn_mode, btn_clear, btn_start_stop};
   assign btn_edge = btn_q & ~btn_prev_q;

   assign tick       = (state_q == ST_RUNNING) && (cnt_q == CNT_MAX);
   assign count_down = down & CD_EN;
   assign at_zero    = (mt_q == 4'd0) && (mu_q == 4'd0) && (st_q == 4'd0) && (su_q == 4'd0);

   // Digit values after one tick, with the carry/borrow rippling through the
   // four digits combinationally.
   always_comb begin
      nx_mt   = mt_q;
      nx_mu   = mu_q;
      nx_st   = st_q;
      nx_su   = su_q;
      nx_wrap = 1'b0;
      if (count_down) begin
         if (su_q != 4'd0) nx_su = su_q - 4'd1;
         else begin
            nx_su = 4'd9;
            if (st_q != 4'd0) nx_st = st_q - 4'd1;
            else begin
               nx_st = 4'd5;
               if (mu_q != 4'd0) nx_mu = mu_q - 4'd1;
               else begin
                  nx_mu = 4'd9;
                  nx_mt = (mt_q != 4'd0) ? mt_q - 4'd1 : 4'd5;
               end
            end
         end
      end else begin
         if (su_q != 4'd9) nx_su = su_q + 4'd1;
         else begin
            nx_su = 4'd0;
            if (st_q != 4'd5) nx_st = st_q + 4'd1;
            else begin
               nx_st = 4'd0;
               if (mu_q != 4'd9) nx_mu = mu_q + 4'd1;
               else begin
                  nx_mu = 4'd0;
                  if (mt_q != 4'd5) nx_mt = mt_q + 4'd1;
                  else begin
                     nx_mt   = 4'd0;
                     nx_wrap = 1'b1;
                  end
               end
            end
         end
      end
   end

   assign nx_zero = (nx_mt == 4'd0) && (nx_mu == 4'd0) && (nx_st == 4'd0) && (nx_su == 4'd0);

   // Mode FSM and digit update. Within a state, the highest-priority button
   // that has an effect there wins (clear > mode > start_stop > inc); buttons
   // a state ignores never block lower-priority ones.
   always_comb begin
      state_d    = state_q;
      mt_d       = mt_q;
      mu_d       = mu_q;
      st_d       = st_q;
      su_d       = su_q;
      rollover_d = 1'b0;
      done_d     = 1'b0;
      case (state_q)
         ST_STOPPED: begin
            if (btn_edge[B_CLR]) begin
               {mt_d, mu_d, st_d, su_d} = 16'h0000;
            end else if (btn_edge[B_MODE]) begin
               state_d = ST_SET_MIN;
            end else if (btn_edge[B_SS] && !(count_down && at_zero)) begin
               state_d = ST_RUNNING;
            end
         end
         ST_RUNNING: begin
            if (btn_edge[B_CLR]) begin
               // A tick in the same cycle is dropped.
               {mt_d, mu_d, st_d, su_d} = 16'h0000;
               state_d = ST_STOPPED;
            end else begin
               if (tick) begin
                  {mt_d, mu_d, st_d, su_d} = {nx_mt, nx_mu, nx_st, nx_su};
                  rollover_d = nx_wrap;
                  if (count_down && nx_zero) begin
                     done_d  = 1'b1;
                     state_d = ST_STOPPED;
                  end
               end
               // A coincident tick still advances the digits before stopping.
               if (btn_edge[B_SS]) state_d = ST_STOPPED;
            end
         end
         ST_SET_MIN: begin
            if (btn_edge[B_CLR]) begin
               {mt_d, mu_d, st_d, su_d} = 16'h0000;
            end else if (btn_edge[B_MODE]) begin
               state_d = ST_SET_SEC;
            end else if (btn_edge[B_INC]) begin
               if (mu_q == 4'd9) begin
                  mu_d = 4'd0;
                  mt_d = (mt_q == 4'd5) ? 4'd0 : mt_q + 4'd1;
               end else begin
                  mu_d = mu_q + 4'd1;
               end
            end
         end
         ST_SET_SEC: begin
            if (btn_edge[B_CLR]) begin
               {mt_d, mu_d, st_d, su_d} = 16'h0000;
            end else if (btn_edge[B_MODE]) begin
               state_d = ST_STOPPED;
            end else if (btn_edge[B_INC]) begin
               // Seconds wrap without carrying into minutes.
               if (su_q == 4'd9) begin
                  su_d = 4'd0;
                  st_d = (st_q == 4'd5) ? 4'd0 : st_q + 4'd1;
               end else begin
                  su_d = su_q + 4'd1;
               end
            end
         end
         default: state_d = ST_STOPPED;
      endcase
   end

   // The prescaler only advances while RUNNING continues; leaving or entering
   // RUNNING restarts a full second.
   always_comb begin
      cnt_d = '0;
      if ((state_q == ST_RUNNING) && (state_d == ST_RUNNING) && !tick) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         btn_q      <= '0;
         btn_prev_q <= '0;
         state_q    <= ST_STOPPED;
         cnt_q      <= '0;
         mt_q       <= '0;
         mu_q       <= '0;
         st_q       <= '0;
         su_q       <= '0;
         rollover_q <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         btn_q      <= btn_in;
         btn_prev_q <= btn_q;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         mt_q       <= mt_d;
         mu_q       <= mu_d;
         st_q       <= st_d;
         su_q       <= su_d;
         rollover_q <= rollover_d;
         done_q     <= done_d;
      end
   end

   assign min_tens  = mt_q;
   assign min_units = mu_q;
   assign sec_tens  = st_q;
   assign sec_units = su_q;
   assign state     = state_q;
   assign running   = (state_q == ST_RUNNING);
   assign rollover  = rollover_q;
   assign done      = done_q;

endmodule

// File: tb/tb_cronometro_ctrl.sv
// Bench for cronometro_ctrl: directed scenarios followed by random button
// traffic, all checked every cycle against a reference model that keeps the
// time as a plain seconds count (0..3599).
module tb_cronometro_ctrl;

   localparam int TD = 4;
`ifdef COUNTDOWN_EN
   localparam bit CD = 1'b1;
`else
   localparam bit CD = 1'b0;
`endif

   // ---------------- clock / reset / DUT ----------------
   logic clock = 1'b0;
   logic reset;
   logic bss, bclr, bmode, binc, down;
   logic [3:0] mt, mu, st, su;
   logic [1:0] state;
   logic running, rollover, done;

   always #5 clock = ~clock;

   cronometro_ctrl #(.TICK_DIV(TD)) dut (
      .clock(clock), .reset(reset),
      .btn_start_stop(bss), .btn_clear(bclr), .btn_mode(bmode), .btn_inc(binc),
      .down(down),
      .min_tens(mt), .min_units(mu), .sec_tens(st), .sec_units(su),
      .state(state), .running(running), .rollover(rollover), .done(done)
   );

   // ---------------- scoreboard ----------------
   int n_cmp = 0;
   int n_err = 0;
   logic [20:0] exp_q[$];

   // Reference model: seconds count, mode number, button pipeline, phase.
   logic [3:0] m_bq, m_bp;
   int m_state, m_secs, m_phase;
   bit m_roll, m_done;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int dut_secs();
      return int'(mt) * 600 + int'(mu) * 60 + int'(st) * 10 + int'(su);
   endfunction

   function automatic logic [20:0] pack_exp();
      int mins;
      int s;
      mins = m_secs / 60;
      s = m_secs % 60;
      return {4'(mins / 10), 4'(mins % 10), 4'(s / 10), 4'(s % 10),
              2'(m_state), (m_state == 1), m_roll, m_done};
   endfunction

   task automatic model_reset();
      m_bq = '0; m_bp = '0;
      m_state = 0; m_secs = 0; m_phase = 0;
      m_roll = 1'b0; m_done = 1'b0;
   endtask

   // b = {inc, mode, clear, start_stop}
   task automatic model_step(input logic [3:0] b, input logic dn);
      logic [3:0] ed;
      bit tick, cd;
      int ns, secs;
      ed = m_bq & ~m_bp;
      tick = (m_state == 1) && (m_phase == TD - 1);
      cd = CD && dn;
      ns = m_state;
      secs = m_secs;
      m_roll = 1'b0;
      m_done = 1'b0;
      case (m_state)
         0: begin
            if (ed[1]) secs = 0;
            else if (ed[2]) ns = 2;
            else if (ed[0] && !(cd && secs == 0)) ns = 1;
         end
         1: begin
            if (ed[1]) begin
               secs = 0;
               ns = 0;
            end else begin
               if (tick) begin
                  if (cd) begin
                     secs = (secs + 3599) % 3600;
                     if (secs == 0) begin
                        m_done = 1'b1;
                        ns = 0;
                     end
                  end else begin
                     secs = (secs + 1) % 3600;
                     m_roll = (secs == 0);
                  end
               end
               if (ed[0]) ns = 0;
            end
         end
         2: begin
            if (ed[1]) secs = 0;
            else if (ed[2]) ns = 3;
            else if (ed[3]) secs = ((secs / 60 + 1) % 60) * 60 + secs % 60;
         end
         default: begin
            if (ed[1]) secs = 0;
            else if (ed[2]) ns = 0;
            else if (ed[3]) secs = (secs / 60) * 60 + (secs % 60 + 1) % 60;
         end
      endcase
      m_phase = (m_state == 1 && ns == 1) ? (m_phase + 1) % TD : 0;
      m_state = ns;
      m_secs = secs;
      m_bp = m_bq;
      m_bq = b;
      exp_q.push_back(pack_exp());
   endtask

   task automatic check_all();
      logic [20:0] e;
      e = exp_q.pop_front();
      check_eq("min_tens", mt, e[20:17]);
      check_eq("min_units", mu, e[16:13]);
      check_eq("sec_tens", st, e[12:9]);
      check_eq("sec_units", su, e[8:5]);
      check_eq("state", state, e[4:3]);
      check_eq("running", running, e[2]);
      check_eq("rollover", rollover, e[1]);
      check_eq("done", done, e[0]);
   endtask

   // ---------------- driver tasks ----------------
   task automatic cycle(input logic [3:0] b, input logic dn);
      {binc, bmode, bclr, bss} = b;
      down = dn;
      @(posedge clock);
      model_step(b, dn);
      @(negedge clock);
      check_all();
   endtask

   task automatic press(input int idx, input logic dn);
      cycle(4'(1 << idx), dn);
      cycle(4'b0000, dn);
   endtask

   task automatic press_n(input int idx, input int n, input logic dn);
      for (int i = 0; i < n; i++) press(idx, dn);
   endtask

   // Called at a falling edge: asserts reset mid-cycle and checks outputs
   // before the next rising edge.
   task automatic async_reset();
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      exp_q.push_back(pack_exp());
      check_all();
      check_eq("rst_state", state, 0);
      check_eq("rst_running", running, 0);
      @(negedge clock);
      reset = 1'b0;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [3:0] lv;
      logic dn;
      int n_done;
      bit seen_first;

      reset = 1'b1;
      {binc, bmode, bclr, bss} = 4'b0000;
      down = 1'b0;
      model_reset();
      @(negedge clock);
      @(negedge clock);
      exp_q.push_back(pack_exp());
      check_all();
      reset = 1'b0;

      // Start with start_stop held high; 40 cycles of RUNNING give 00:10.
      for (int i = 0; i < 10 && m_state != 1; i++) cycle(4'b0001, 1'b0);
      for (int i = 0; i < 40; i++) cycle((i < 6) ? 4'b0001 : 4'b0000, 1'b0);
      check_eq("run40_secs", dut_secs(), 10);
      check_eq("run40_state", state, 1);
      press(0, 1'b0);
      check_eq("pause_state", state, 0);

      // Preload 59:58 and run through the wrap.
      press(1, 1'b0);
      press(2, 1'b0);
      press_n(3, 59, 1'b0);
      press(2, 1'b0);
      press_n(3, 58, 1'b0);
      check_eq("preload_secs", dut_secs(), 3598);
      check_eq("preload_state", state, 3);
      press(2, 1'b0);
      press(0, 1'b0);
      for (int i = 0; i < 20 && m_secs != 0; i++) cycle(4'b0000, 1'b0);
      check_eq("wrap_secs", dut_secs(), 0);
      check_eq("wrap_rollover", rollover, 1);
      check_eq("wrap_state", state, 1);
      cycle(4'b0000, 1'b0);
      check_eq("wrap_rollover_end", rollover, 0);
      press(0, 1'b0);

      // Seconds wrap in SET_SEC without touching minutes; mode x3 cycle.
      press(1, 1'b0);
      press(2, 1'b0);
      press_n(3, 3, 1'b0);
      press(2, 1'b0);
      press_n(3, 59, 1'b0);
      check_eq("setsec_59", dut_secs(), 239);
      press(3, 1'b0);
      check_eq("setsec_wrap", dut_secs(), 180);
      press(2, 1'b0);
      check_eq("mode3_state", state, 0);

      // Clear edge coinciding with a tick at 00:09.
      press(1, 1'b0);
      press(0, 1'b0);
      for (int i = 0; i < 100 && !(m_secs == 9 && m_phase == TD - 2); i++) cycle(4'b0000, 1'b0);
      cycle(4'b0010, 1'b0);
      cycle(4'b0000, 1'b0);
      check_eq("clrtick_secs", dut_secs(), 0);
      check_eq("clrtick_state", state, 0);

      // start_stop edge coinciding with a tick at 00:03.
      press(0, 1'b0);
      for (int i = 0; i < 100 && !(m_secs == 3 && m_phase == TD - 2); i++) cycle(4'b0000, 1'b0);
      cycle(4'b0001, 1'b0);
      cycle(4'b0000, 1'b0);
      check_eq("sstick_secs", dut_secs(), 4);
      check_eq("sstick_state", state, 0);

`ifdef COUNTDOWN_EN
      // Count down from 01:00.
      press(1, 1'b1);
      press(2, 1'b1);
      press(3, 1'b1);
      press(2, 1'b1);
      press(2, 1'b1);
      check_eq("cd_preload", dut_secs(), 60);
      press(0, 1'b1);
      n_done = 0;
      seen_first = 1'b0;
      for (int i = 0; i < 400 && m_state == 1; i++) begin
         cycle(4'b0000, 1'b1);
         if (done === 1'b1) n_done++;
         if (!seen_first && m_secs != 60) begin
            seen_first = 1'b1;
            check_eq("cd_first_tick", dut_secs(), 59);
         end
      end
      check_eq("cd_end_secs", dut_secs(), 0);
      check_eq("cd_end_state", state, 0);
      check_eq("cd_done_count", n_done, 1);
      press(0, 1'b1);
      cycle(4'b0000, 1'b1);
      check_eq("cd_restart_ignored", state, 0);
`endif

      // Reset while running at 12:34.
      press(1, 1'b0);
      press(2, 1'b0);
      press_n(3, 12, 1'b0);
      press(2, 1'b0);
      press_n(3, 34, 1'b0);
      press(2, 1'b0);
      press(0, 1'b0);
      cycle(4'b0000, 1'b0);
      check_eq("pre_rst_secs", dut_secs(), 754);
      check_eq("pre_rst_running", running, 1);
      async_reset();
      check_eq("rst_secs", dut_secs(), 0);

      // Random button traffic with occasional direction changes and resets.
      lv = 4'b0000;
      dn = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         for (int k = 0; k < 4; k++) begin
            // clear is toggled less often so the count can build up.
            if ($urandom_range(0, (k == 1) ? 29 : 5) == 0) lv[k] = ~lv[k];
         end
         if ($urandom_range(0, 49) == 0) dn = ~dn;
         if ($urandom_range(0, 499) == 0) async_reset();
         else cycle(lv, dn);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
